load_store_unit: RTL and testbench

- Memory-access stage that sits directly upstream of the word-addressed data memory in the RV32 core.
- Takes one load/store request per transaction from execute over a valid/ready handshake.
- Checks alignment, then drives a word-aligned access with byte enables and lane-shifted store data, and holds it until memory acknowledges.
- For loads, extracts the addressed byte/half/word, sign- or zero-extends it, and returns it to writeback with the destination tag.

---
 rtl/load_store_unit.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage between execute and the word-addressed
// data memory. Accepts one load/store per valid/ready handshake, rejects
// misaligned or reserved-size requests, drives a word-aligned access with
// byte enables and lane-shifted store data, and returns sign/zero-extended
// load data with the destination tag.
//
// Optional LR/SC support is compiled in when the macro LSU_LRSC_EN is
// defined. It adds the req_lr/req_sc inputs and a one-entry reservation.
module load_store_unit #(
  parameter int WIDTH_ADDR = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // request from execute
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [WIDTH_ADDR-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [4:0]            req_rd,
`ifdef LSU_LRSC_EN
  input  logic                  req_lr,
  input  logic                  req_sc,
`endif
  // response to writeback
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [4:0]            resp_rd,
  output logic                  resp_err,
  // data memory
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [WIDTH_ADDR-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // FSM and latched request fields
  state_e                state_q, state_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [1:0]            off_q, off_d;

  // registered outputs
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [WIDTH_ADDR-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic [4:0]            resp_rd_q, resp_rd_d;
  logic                  resp_err_q, resp_err_d;

  // request decode
  logic                  is_lr;
  logic                  is_sc;
  logic [1:0]            eff_size;
  logic                  eff_we;
  logic                  misaligned;
  logic [3:0]            be_base;
  logic [3:0]            be_shift;
  logic [DATA_WIDTH-1:0] wdata_shift;
  logic [DATA_WIDTH-1:0] rdata_shift;
  logic [DATA_WIDTH-1:0] load_data;

`ifdef LSU_LRSC_EN
  logic                  resv_valid_q, resv_valid_d;
  logic [WIDTH_ADDR-3:0] resv_addr_q, resv_addr_d;
  logic                  resv_match;

  assign is_lr      = req_lr;
  assign is_sc      = req_sc;
  assign resv_match = resv_valid_q && (resv_addr_q == req_addr[WIDTH_ADDR-1:2]);
`else
  assign is_lr = 1'b0;
  assign is_sc = 1'b0;
`endif

  // LR/SC are always word-sized; LR always reads, SC always writes.
  assign eff_size = (is_lr || is_sc) ? SIZE_W : req_size;
  assign eff_we   = is_lr ? 1'b0 : (is_sc ? 1'b1 : req_we);

  // Alignment check and byte-enable base pattern for the effective size.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    misaligned = 1'b1;
    be_base    = 4'b0000;
    case (eff_size)
      SIZE_B: begin
        misaligned = 1'b0;
        be_base    = 4'b0001;
      end
      SIZE_H: begin
        misaligned = req_addr[0];
        be_base    = 4'b0011;
      end
      SIZE_W: begin
        misaligned = (req_addr[1:0] != 2'b00);
        be_base    = 4'b1111;
      end
      default: begin
        misaligned = 1'b1;
        be_base    = 4'b0000;
      end
    endcase
  end

  assign be_shift    = be_base << req_addr[1:0];
  assign wdata_shift = req_wdata << {req_addr[1:0], 3'b000};

  // Load lane extraction: bring the addressed lane down to bit 0, then extend.
  assign rdata_shift = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_data = rdata_shift;
    case (size_q)
      SIZE_B: load_data = uns_q ? {{(DATA_WIDTH-8){1'b0}}, rdata_shift[7:0]}
                                : {{(DATA_WIDTH-8){rdata_shift[7]}}, rdata_shift[7:0]};
      SIZE_H: load_data = uns_q ? {{(DATA_WIDTH-16){1'b0}}, rdata_shift[15:0]}
                                : {{(DATA_WIDTH-16){rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_data = rdata_shift;
    endcase
  end

  // Next-state and registered-output logic for the IDLE/ACCESS/RESP sequence.
  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_rd_d    = resp_rd_q;
    resp_err_d   = resp_err_q;
`ifdef LSU_LRSC_EN
    resv_valid_d = resv_valid_q;
    resv_addr_d  = resv_addr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          size_d    = eff_size;
          uns_d     = req_unsigned;
          off_d     = req_addr[1:0];
          resp_rd_d = req_rd;
          if (misaligned) begin
            // rejected without touching memory; reservation left alone
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
`ifdef LSU_LRSC_EN
          end else if (is_sc && !resv_match) begin
            // failed SC: no access, report 1, reservation dropped
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            resv_valid_d = 1'b0;
`endif
          end else begin
            state_d     = ST_ACCESS;
            mem_en_d    = 1'b1;
            mem_we_d    = eff_we;
            mem_be_d    = eff_we ? be_shift : 4'b0000;
            mem_addr_d  = {req_addr[WIDTH_ADDR-1:2], 2'b00};
            mem_wdata_d = eff_we ? wdata_shift : '0;
`ifdef LSU_LRSC_EN
            if (is_lr) begin
              resv_valid_d = 1'b1;
              resv_addr_d  = req_addr[WIDTH_ADDR-1:2];
            end else if (is_sc) begin
              resv_valid_d = 1'b0;
            end else if (eff_we && resv_match) begin
              resv_valid_d = 1'b0;
            end
`endif
          end
        end
      end

      ST_ACCESS: begin
        // memory-side signals stay frozen until the memory acknowledges
        if (mem_ready) begin
          state_d      = ST_RESP;
          mem_en_d     = 1'b0;
          mem_we_d     = 1'b0;
          mem_be_d     = 4'b0000;
          mem_addr_d   = '0;
          mem_wdata_d  = '0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = mem_we_q ? '0 : load_data;
        end
      end

      ST_RESP: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_rd_d    = '0;
        resp_err_d   = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples its _d value from before this edge.
    if (rst) begin
      state_q      <= ST_IDLE;
      size_q       <= SIZE_B;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'b0000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_rd_q    <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_rd_q    <= resp_rd_d;
      resp_err_q   <= resp_err_d;
    end
  end

`ifdef LSU_LRSC_EN
  // Reservation register for LR/SC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
    end else begin
      resv_valid_q <= resv_valid_d;
      resv_addr_q  <= resv_addr_d;
    end
  end
`endif

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_rd    = resp_rd_q;
  assign resp_err   = resp_err_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit. Inputs change on the falling edge,
// outputs are sampled on the falling edge. Define LSU_LRSC_EN to also
// exercise LR/SC.
module tb_load_store_unit;

  localparam int WIDTH_ADDR = 32;
  localparam int DATA_WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [WIDTH_ADDR-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [4:0]            req_rd;
  logic                  req_lr;
  logic                  req_sc;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic [4:0]            resp_rd;
  logic                  resp_err;
  logic                  mem_en;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [WIDTH_ADDR-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.WIDTH_ADDR(WIDTH_ADDR), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
`ifdef LSU_LRSC_EN
    .req_lr       (req_lr),
    .req_sc       (req_sc),
`endif
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_rd      (resp_rd),
    .resp_err     (resp_err),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
  );

  always #5 clk = ~clk;

  // Present one request for a single cycle; returns just after the handshake edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic lr, input logic sc);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_rd       = rd;
    req_lr       = lr;
    req_sc       = sc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_lr    = 1'b0;
    req_sc    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0; req_lr = 1'b0; req_sc = 1'b0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b expected 0", mem_en); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if ({mem_we, mem_be, mem_addr, mem_wdata, resp_rdata, resp_rd, resp_err} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs be=%b addr=%h wdata=%h rdata=%h expected all 0", mem_be, mem_addr, mem_wdata, resp_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_byte();
    // LB 0x103 from word 0x80FF1234 -> top byte 0x80, sign-extended
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL lb_ready_idle: got %b expected 1", req_ready); end
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 5'd5, 1'b0, 1'b0);
    @(negedge clk);  // T+1
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL lb_mem_en: got %b expected 1", mem_en); end
    checks++; if (mem_addr !== 32'h0000_0100) begin errors++; $display("FAIL lb_mem_addr: got %h expected 00000100", mem_addr); end
    checks++; if (mem_be !== 4'b0000 || mem_we !== 1'b0) begin errors++; $display("FAIL lb_mem_be_we: got be=%b we=%b expected be=0000 we=0", mem_be, mem_we); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL lb_ready_busy: got %b expected 0", req_ready); end
    mem_rdata = 32'h80FF_1234; mem_ready = 1'b1;
    @(negedge clk);  // T+2
    mem_ready = 1'b0;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL lb_resp_valid: got %b expected 1", resp_valid); end
    checks++; if (resp_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata: got %h expected ffffff80", resp_rdata); end
    checks++; if (resp_rd !== 5'd5 || resp_err !== 1'b0) begin errors++; $display("FAIL lb_rd_err: got rd=%0d err=%b expected rd=5 err=0", resp_rd, resp_err); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL lb_mem_en_drop: got %b expected 0", mem_en); end
    @(negedge clk);  // T+3
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL lb_pulse_end: got valid=%b ready=%b expected valid=0 ready=1", resp_valid, req_ready); end

    // LBU same address -> zero-extended
    issue(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 5'd6, 1'b0, 1'b0);
    @(negedge clk);
    mem_rdata = 32'h80FF_1234; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_rdata: got valid=%b rdata=%h expected valid=1 rdata=00000080", resp_valid, resp_rdata); end
  endtask

  task automatic test_load_half();
    // LH 0x106 from word 0x80017FFF -> upper half 0x8001
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0106, 32'h0, 5'd7, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (mem_addr !== 32'h0000_0104) begin errors++; $display("FAIL lh_mem_addr: got %h expected 00000104", mem_addr); end
    mem_rdata = 32'h8001_7FFF; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++; if (resp_rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_rdata: got %h expected ffff8001", resp_rdata); end
    issue(1'b0, 2'b01, 1'b1, 32'h0000_0106, 32'h0, 5'd7, 1'b0, 1'b0);
    @(negedge clk);
    mem_rdata = 32'h8001_7FFF; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++; if (resp_rdata !== 32'h0000_8001) begin errors++; $display("FAIL lhu_rdata: got %h expected 00008001", resp_rdata); end
    // LH 0x104 -> lower half 0x7FFF, positive
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0104, 32'h0, 5'd7, 1'b0, 1'b0);
    @(negedge clk);
    mem_rdata = 32'h8001_7FFF; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++; if (resp_rdata !== 32'h0000_7FFF) begin errors++; $display("FAIL lh_low_rdata: got %h expected 00007fff", resp_rdata); end
  endtask

  task automatic test_store();
    // SH 0x102 wdata 0xABCD -> be 1100, data in upper half
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_ABCD, 5'd9, 1'b0, 1'b0);
    @(negedge clk);  // T+1
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL sh_en_we: got en=%b we=%b expected 1 1", mem_en, mem_we); end
    checks++; if (mem_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b expected 1100", mem_be); end
    checks++; if (mem_wdata !== 32'hABCD_0000) begin errors++; $display("FAIL sh_wdata: got %h expected abcd0000", mem_wdata); end
    checks++; if (mem_addr !== 32'h0000_0100) begin errors++; $display("FAIL sh_addr: got %h expected 00000100", mem_addr); end
    mem_rdata = 32'hFFFF_FFFF; mem_ready = 1'b1;
    @(negedge clk);  // T+2
    mem_ready = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0) begin errors++; $display("FAIL sh_resp: got valid=%b rdata=%h expected valid=1 rdata=00000000", resp_valid, resp_rdata); end
    // SB 0x101 wdata 0xAB -> be 0010, data in byte 1
    issue(1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_00AB, 5'd9, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (mem_be !== 4'b0010 || mem_wdata !== 32'h0000_AB00) begin errors++; $display("FAIL sb_be_wdata: got be=%b wdata=%h expected be=0010 wdata=0000ab00", mem_be, mem_wdata); end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    // SW 0x108 -> be 1111, unshifted
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0108, 32'h1234_5678, 5'd9, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (mem_be !== 4'b1111 || mem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL sw_be_wdata: got be=%b wdata=%h expected be=1111 wdata=12345678", mem_be, mem_wdata); end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
  endtask

  task automatic test_misaligned();
    logic [1:0]  sizes [3];
    logic [31:0] addrs [3];
    sizes[0] = 2'b10; addrs[0] = 32'h0000_0102;  // LW misaligned
    sizes[1] = 2'b11; addrs[1] = 32'h0000_0100;  // reserved size
    sizes[2] = 2'b01; addrs[2] = 32'h0000_0101;  // LH odd address
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, sizes[i], 1'b0, addrs[i], 32'h0, 5'd3, 1'b0, 1'b0);
      @(negedge clk);  // T+1
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL misal%0d_mem_en: got %b expected 0", i, mem_en); end
      checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
        errors++; $display("FAIL misal%0d_resp: got valid=%b err=%b rdata=%h expected 1 1 00000000", i, resp_valid, resp_err, resp_rdata);
      end
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL misal%0d_after: got valid=%b en=%b expected 0 0", i, resp_valid, mem_en); end
    end
  endtask

  task automatic test_stall();
    bit stable_ok = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 5'd11, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);  // T+1..T+3, mem_ready low
      mem_rdata = 32'hDEAD_0000 + i;
      if (mem_en !== 1'b1 || mem_addr !== 32'h0000_0200 || mem_be !== 4'b0000 ||
          req_ready !== 1'b0 || resp_valid !== 1'b0) stable_ok = 1'b0;
    end
    checks++; if (!stable_ok) begin errors++; $display("FAIL stall_hold: got en=%b addr=%h be=%b ready=%b expected stable 1 00000200 0000 0", mem_en, mem_addr, mem_be, req_ready); end
    @(negedge clk);  // T+4
    checks++; if (mem_en !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL stall_t4: got en=%b valid=%b expected 1 0", mem_en, resp_valid); end
    mem_rdata = 32'h1357_9BDF; mem_ready = 1'b1;
    @(negedge clk);  // T+5
    mem_ready = 1'b0; mem_rdata = 32'h0;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h1357_9BDF || resp_rd !== 5'd11) begin
      errors++; $display("FAIL stall_resp: got valid=%b rdata=%h rd=%0d expected 1 13579bdf 11", resp_valid, resp_rdata, resp_rd);
    end
  endtask

  task automatic test_reset_mid_access();
    bit saw_resp = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0204, 32'h0, 5'd12, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rstmid_pre_en: got %b expected 1", mem_en); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rstmid_async_drop: got %b expected 0", mem_en); end
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || mem_en !== 1'b0) saw_resp = 1'b1;
    end
    mem_ready = 1'b0;
    checks++; if (saw_resp) begin errors++; $display("FAIL rstmid_no_resp: got a response or access after reset expected none"); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", req_ready); end
  endtask

`ifdef LSU_LRSC_EN
  task automatic test_lrsc();
    // LR 0x300
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 5'd1, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL lr_access: got en=%b we=%b expected 1 0", mem_en, mem_we); end
    mem_rdata = 32'hCAFE_F00D; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++; if (resp_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL lr_rdata: got %h expected cafef00d", resp_rdata); end
    // SC 0x300 succeeds
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'h0000_0055, 5'd2, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1111 || mem_wdata !== 32'h55) begin
      errors++; $display("FAIL sc_ok_access: got en=%b we=%b be=%b wdata=%h expected 1 1 1111 00000055", mem_en, mem_we, mem_be, mem_wdata);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0) begin errors++; $display("FAIL sc_ok_resp: got valid=%b rdata=%h expected 1 00000000", resp_valid, resp_rdata); end
    // second SC fails
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'h0000_0066, 5'd2, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (mem_en !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== 32'h1) begin
      errors++; $display("FAIL sc_again: got en=%b valid=%b rdata=%h expected 0 1 00000001", mem_en, resp_valid, resp_rdata);
    end
    @(negedge clk);
    // LR, SW same word, SC fails
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 5'd1, 1'b1, 1'b0);
    @(negedge clk); mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'h0000_0077, 5'd0, 1'b0, 1'b0);
    @(negedge clk); mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'h0000_0088, 5'd2, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (mem_en !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== 32'h1) begin
      errors++; $display("FAIL sc_after_sw: got en=%b valid=%b rdata=%h expected 0 1 00000001", mem_en, resp_valid, resp_rdata);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_load_byte();
    test_load_half();
    test_store();
    test_misaligned();
    test_stall();
    test_reset_mid_access();
`ifdef LSU_LRSC_EN
    test_lrsc();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
